data_sram_bridge: RTL and testbench



---
 rtl/mem_bridge_pkg.sv | 36 +++
 rtl/data_sram_bridge.sv | 132 +++++++++++++
 tb/tb_data_sram_bridge.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge_pkg
// Description : Shared types, bus-size encodings and the byte-enable to
//               transfer-size mapping for the data SRAM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bridge_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // bus_size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Single lanes are byte accesses, aligned lane pairs are halfwords, and
    // everything else (loads included) is treated as a full word.
    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
            4'b0011, 4'b1100:                   size = SIZE_HALF;
            default:                            size = SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_bridge
// Description : Converts the core's single-cycle M-stage data port into a
//               split-handshake SRAM-like bus (req / addr_ok / data_ok).
//               Stalls the pipeline while a transaction is outstanding and
//               holds returned load data until the M-stage instruction
//               retires.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              pipe_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t            r_state_q, w_state_d;
    logic              r_wr_q,    w_wr_d;
    logic [1:0]        r_size_q,  w_size_d;
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic [DATA_W-1:0] r_wdata_q, w_wdata_d;
    logic [DATA_W-1:0] r_rdata_q, w_rdata_d;

    logic [1:0]        w_new_size;
    logic [ADDR_W-1:0] w_new_addr;

    // Transfer size and bus address of the access presented this cycle;
    // word accesses are forced onto a word boundary.
    assign w_new_size = wen_to_size(cpu_wen);
    assign w_new_addr = (w_new_size == SIZE_WORD) ? {cpu_addr[ADDR_W-1:2], 2'b00}
                                                  : cpu_addr;

    // Next-state and latched-field update for the request/response handshake
    always_comb begin
        w_state_d = r_state_q;
        w_wr_d    = r_wr_q;
        w_size_d  = r_size_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_rdata_d = r_rdata_q;
        case (r_state_q)
            ST_IDLE: begin
                if (cpu_en) begin
                    w_wr_d    = |cpu_wen;
                    w_size_d  = w_new_size;
                    w_addr_d  = w_new_addr;
                    w_wdata_d = cpu_wdata;
                    w_state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Request fields stay frozen until the slave accepts them
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        if (!r_wr_q) begin
                            w_rdata_d = bus_rdata;
                        end
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    if (!r_wr_q) begin
                        w_rdata_d = bus_rdata;
                    end
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold the result until the M-stage instruction advances
                if (!pipe_stall) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State and latched request/response registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_wr_q    <= 1'b0;
            r_size_q  <= SIZE_BYTE;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_wr_q    <= w_wr_d;
            r_size_q  <= w_size_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
        end
    end

    // Bus side is driven purely from state and latched fields
    assign bus_req   = (r_state_q == ST_REQ);
    assign bus_wr    = r_wr_q;
    assign bus_size  = r_size_q;
    assign bus_addr  = r_addr_q;
    assign bus_wdata = r_wdata_q;

    // Stall is combinational so it covers the very first cycle of cpu_en
    assign cpu_stall = cpu_en & (r_state_q != ST_DONE);
    assign cpu_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_bridge
// Description : Directed self-checking bench for data_sram_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              cpu_en;
    logic [3:0]        cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              pipe_stall;
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    logic [3:0]  sm_wen   [0:4];
    logic [31:0] sm_addr  [0:4];
    logic [31:0] sm_wdata [0:4];
    logic [1:0]  sm_size  [0:4];
    logic [31:0] sm_baddr [0:4];

    data_sram_bridge #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_en     (cpu_en),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .pipe_stall (pipe_stall),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_size   (bus_size),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic en, input logic [3:0] wen,
                             input logic [31:0] addr, input logic [31:0] wdata);
        cpu_en    = en;
        cpu_wen   = wen;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic drive_bus(input logic aok, input logic dok, input logic [31:0] rdata);
        bus_addr_ok = aok;
        bus_data_ok = dok;
        bus_rdata   = rdata;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pipe_stall = 1'b0;
        drive_cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        drive_bus(1'b0, 1'b0, 32'h0);
        step();
        step();
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL reset_bus_wr: got %b want 0", bus_wr); end
        checks++; if (bus_size !== 2'd0) begin errors++; $display("FAIL reset_bus_size: got %0d want 0", bus_size); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_en0: got %b want 0", cpu_stall); end
        cpu_en = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_en1: got %b want 1", cpu_stall); end
        step();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_hold_req: got %b want 0", bus_req); end
        cpu_en = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_load_zero_wait();
        drive_cpu(1'b1, 4'b0000, 32'h0000_1004, 32'h0);
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_c0_stall: got %b want 1", cpu_stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL load_c0_req: got %b want 0", bus_req); end
        step();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL load_c1_req: got %b want 1", bus_req); end
        checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL load_c1_wr: got %b want 0", bus_wr); end
        checks++; if (bus_size !== 2'd2) begin errors++; $display("FAIL load_c1_size: got %0d want 2", bus_size); end
        checks++; if (bus_addr !== 32'h0000_1004) begin errors++; $display("FAIL load_c1_addr: got %h want 00001004", bus_addr); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_c1_stall: got %b want 1", cpu_stall); end
        drive_bus(1'b1, 1'b1, 32'hDEAD_BEEF);
        step();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL load_c2_req: got %b want 0", bus_req); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL load_c2_stall: got %b want 0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_c2_rdata: got %h want deadbeef", cpu_rdata); end
        step();
        drive_cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL load_c3_req: got %b want 0", bus_req); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_c3_rdata: got %h want deadbeef", cpu_rdata); end
    endtask

    task automatic test_byte_store_waits();
        drive_cpu(1'b1, 4'b0100, 32'h0000_2002, 32'h00AB_0000);
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL bst_c0_stall: got %b want 1", cpu_stall); end
        // Three REQ cycles, addr_ok only on the third
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL bst_req_c%0d: got %b want 1", i + 1, bus_req); end
            checks++; if (bus_wr !== 1'b1) begin errors++; $display("FAIL bst_wr_c%0d: got %b want 1", i + 1, bus_wr); end
            checks++; if (bus_size !== 2'd0) begin errors++; $display("FAIL bst_size_c%0d: got %0d want 0", i + 1, bus_size); end
            checks++; if (bus_addr !== 32'h0000_2002) begin errors++; $display("FAIL bst_addr_c%0d: got %h want 00002002", i + 1, bus_addr); end
            checks++; if (bus_wdata !== 32'h00AB_0000) begin errors++; $display("FAIL bst_wdata_c%0d: got %h want 00ab0000", i + 1, bus_wdata); end
            checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL bst_stall_c%0d: got %b want 1", i + 1, cpu_stall); end
            if (i == 2) drive_bus(1'b1, 1'b0, 32'h0);
        end
        // Four WAIT cycles, data_ok only on the fourth; bus_rdata must not be captured for a write
        for (int i = 0; i < 4; i++) begin
            step();
            drive_bus(1'b0, (i == 3), 32'h5555_5555);
            #1;
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL bst_wait_req_%0d: got %b want 0", i, bus_req); end
            checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL bst_wait_stall_%0d: got %b want 1", i, cpu_stall); end
        end
        step();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL bst_done_stall: got %b want 0", cpu_stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL bst_done_req: got %b want 0", bus_req); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bst_done_rdata: got %h want deadbeef", cpu_rdata); end
        step();
        drive_cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL bst_idle_req: got %b want 0", bus_req); end
    endtask

    task automatic test_size_map();
        sm_wen[0] = 4'b1111; sm_addr[0] = 32'h0000_3006; sm_wdata[0] = 32'hCAFE_F00D; sm_size[0] = 2'd2; sm_baddr[0] = 32'h0000_3004;
        sm_wen[1] = 4'b1100; sm_addr[1] = 32'h0000_4002; sm_wdata[1] = 32'h1234_0000; sm_size[1] = 2'd1; sm_baddr[1] = 32'h0000_4002;
        sm_wen[2] = 4'b0011; sm_addr[2] = 32'h0000_4001; sm_wdata[2] = 32'h0000_5678; sm_size[2] = 2'd1; sm_baddr[2] = 32'h0000_4001;
        sm_wen[3] = 4'b0001; sm_addr[3] = 32'h0000_5003; sm_wdata[3] = 32'h0000_0077; sm_size[3] = 2'd0; sm_baddr[3] = 32'h0000_5003;
        sm_wen[4] = 4'b0110; sm_addr[4] = 32'h0000_5003; sm_wdata[4] = 32'h00AA_BB00; sm_size[4] = 2'd2; sm_baddr[4] = 32'h0000_5000;
        for (int i = 0; i < 5; i++) begin
            drive_cpu(1'b1, sm_wen[i], sm_addr[i], sm_wdata[i]);
            drive_bus(1'b0, 1'b0, 32'h0);
            step();
            checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL size_req_%0d: got %b want 1", i, bus_req); end
            checks++; if (bus_wr !== 1'b1) begin errors++; $display("FAIL size_wr_%0d: got %b want 1", i, bus_wr); end
            checks++; if (bus_size !== sm_size[i]) begin errors++; $display("FAIL size_size_%0d: got %0d want %0d", i, bus_size, sm_size[i]); end
            checks++; if (bus_addr !== sm_baddr[i]) begin errors++; $display("FAIL size_addr_%0d: got %h want %h", i, bus_addr, sm_baddr[i]); end
            checks++; if (bus_wdata !== sm_wdata[i]) begin errors++; $display("FAIL size_wdata_%0d: got %h want %h", i, bus_wdata, sm_wdata[i]); end
            drive_bus(1'b1, 1'b1, 32'hFFFF_FFFF);
            step();
            drive_bus(1'b0, 1'b0, 32'h0);
            drive_cpu(1'b0, 4'b0000, 32'h0, 32'h0);
            #1;
            checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL size_rdata_%0d: got %h want deadbeef", i, cpu_rdata); end
            step();
        end
    endtask

    task automatic test_held_stall();
        drive_cpu(1'b1, 4'b0000, 32'h0000_6000, 32'h0);
        #1;
        step();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL hold_c1_req: got %b want 1", bus_req); end
        drive_bus(1'b1, 1'b1, 32'h1234_5678);
        // Three DONE cycles held by pipe_stall, with stray data_ok pulses
        for (int i = 0; i < 3; i++) begin
            step();
            pipe_stall = 1'b1;
            drive_bus(1'b0, 1'b1, 32'hFFFF_0000 + i);
            #1;
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL hold_req_%0d: got %b want 0", i, bus_req); end
            checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL hold_stall_%0d: got %b want 0", i, cpu_stall); end
            checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL hold_rdata_%0d: got %h want 12345678", i, cpu_rdata); end
        end
        step();
        pipe_stall = 1'b0;
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL hold_release_stall: got %b want 0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL hold_release_rdata: got %h want 12345678", cpu_rdata); end
        step();
        drive_cpu(1'b1, 4'b0000, 32'h0000_6004, 32'h0);
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL hold_idle_stall: got %b want 1", cpu_stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL hold_idle_req: got %b want 0", bus_req); end
        step();
        checks++; if (bus_addr !== 32'h0000_6004) begin errors++; $display("FAIL hold_next_addr: got %h want 00006004", bus_addr); end
        drive_bus(1'b1, 1'b1, 32'h0BAD_F00D);
        step();
        drive_bus(1'b0, 1'b0, 32'h0);
        drive_cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        checks++; if (cpu_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL hold_next_rdata: got %h want 0badf00d", cpu_rdata); end
        step();
    endtask

    task automatic test_reset_mid_read();
        drive_cpu(1'b1, 4'b0000, 32'h0000_7000, 32'h0);
        #1;
        step();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_c1_req: got %b want 1", bus_req); end
        drive_bus(1'b1, 1'b0, 32'h0);
        step();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rmid_wait_stall: got %b want 1", cpu_stall); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive_cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rmid_after_req: got %b want 0", bus_req); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rmid_after_rdata: got %h want 0", cpu_rdata); end
        step();
        drive_cpu(1'b1, 4'b0000, 32'h0000_7008, 32'h0);
        #1;
        step();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_new_req: got %b want 1", bus_req); end
        checks++; if (bus_addr !== 32'h0000_7008) begin errors++; $display("FAIL rmid_new_addr: got %h want 00007008", bus_addr); end
        drive_bus(1'b1, 1'b1, 32'hA5A5_A5A5);
        step();
        drive_bus(1'b0, 1'b0, 32'h0);
        drive_cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        checks++; if (cpu_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rmid_new_rdata: got %h want a5a5a5a5", cpu_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        drive_cpu(1'b1, 4'b0000, 32'h0000_8000, 32'h0);
        #1;
        step();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL b2b_ld_req: got %b want 1", bus_req); end
        drive_bus(1'b1, 1'b1, 32'h1111_2222);
        step();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (cpu_rdata !== 32'h1111_2222) begin errors++; $display("FAIL b2b_ld_rdata: got %h want 11112222", cpu_rdata); end
        step();
        drive_cpu(1'b1, 4'b1111, 32'h0000_8010, 32'h3333_4444);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL b2b_gap_req: got %b want 0", bus_req); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL b2b_gap_stall: got %b want 1", cpu_stall); end
        step();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL b2b_st_req: got %b want 1", bus_req); end
        checks++; if (bus_wr !== 1'b1) begin errors++; $display("FAIL b2b_st_wr: got %b want 1", bus_wr); end
        checks++; if (bus_addr !== 32'h0000_8010) begin errors++; $display("FAIL b2b_st_addr: got %h want 00008010", bus_addr); end
        checks++; if (bus_wdata !== 32'h3333_4444) begin errors++; $display("FAIL b2b_st_wdata: got %h want 33334444", bus_wdata); end
        drive_bus(1'b1, 1'b0, 32'h0);
        step();
        drive_bus(1'b0, 1'b1, 32'h7777_7777);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL b2b_wait_req: got %b want 0", bus_req); end
        step();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b want 0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h1111_2222) begin errors++; $display("FAIL b2b_done_rdata: got %h want 11112222", cpu_rdata); end
        step();
        drive_cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL b2b_end_req: got %b want 0", bus_req); end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_byte_store_waits();
        test_size_map();
        test_held_stall();
        test_reset_mid_read();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
